uart_8n1: RTL and testbench

//  Full-duplex 8N1 UART: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx.sv | 88 ++++++++
 rtl/uart_8n1.sv | 108 ++++++++++
 tb/tb_uart_8n1.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 8N1 UART: FSM state enums, data width,
// and the baud divisor calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, centre-sampling FSM, LSB-first shift register.
// rx_byte is only overwritten by a frame whose stop bit is high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 byte_available
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]           r_sync;
  logic                 w_rx_s;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync         <= '1;
      r_state        <= RX_IDLE;
      r_cnt          <= '0;
      r_bit          <= '0;
      r_shift        <= '0;
      rx_byte        <= '0;
      byte_available <= 1'b0;
    end else begin
      r_sync         <= {r_sync[0], rx};
      byte_available <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
          if (!w_rx_s && rx_enable) r_state <= RX_START;
        end
        // A start bit that is high again at its centre was only a glitch.
        RX_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'(DATA_BITS - 1)) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              rx_byte        <= r_shift;
              byte_available <= 1'b1;
              r_state        <= RX_IDLE;
            end else begin
              r_state <= RX_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (w_rx_s) r_state <= RX_IDLE;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART top: inline transmitter FSM plus the uart_rx receiver.
// TX and RX share only clock and reset.
module uart_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 12_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_byte,
  input  logic                 tx_enable,
  output logic                 tx_busy,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 byte_available
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: begin
          if (tx_enable) begin
            r_shift <= tx_byte;
            r_cnt   <= '0;
            r_bit   <= '0;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            tx      <= r_shift[0];
            r_state <= TX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (r_bit == 3'(DATA_BITS - 1)) begin
              tx      <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              tx      <= r_shift[1];
              r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        // The last stop-bit cycle doubles as the IDLE acceptance point, so a
        // pending strobe starts the next frame with no idle gap.
        TX_STOP: begin
          if (r_cnt == LAST) begin
            r_cnt <= '0;
            if (tx_enable) begin
              r_shift <= tx_byte;
              r_bit   <= '0;
              tx      <= 1'b0;
              r_state <= TX_START;
            end else begin
              tx_busy <= 1'b0;
              r_state <= TX_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .rx_enable     (rx_enable),
    .rx_byte       (rx_byte),
    .byte_available(byte_available)
  );

endmodule

// File: tb/tb_uart_8n1.sv
// Self-checking bench for uart_8n1: directed table for RX corner cases, TX waveform
// checks, randomized TX/RX against a line-level reference, and a default-rate loopback.
module tb_uart_8n1;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx, tx, tx_enable, tx_busy, rx_enable, byte_available;
  logic [7:0] tx_byte, rx_byte;

  logic       lb_line, lb_tx_enable, lb_busy, lb_avail;
  logic [7:0] lb_tx_byte, lb_rx_byte;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int pulses  = 0;
  int last_pulse_cyc = 0;
  logic [7:0] lb_q[$];
  logic line_buf[0:1023];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       en;
    int         drop_at;
    logic       glitch;
    int         exp_pulses;
    logic [7:0] exp_byte;
  } rx_vec_t;

  rx_vec_t vecs[6];

  always #5 clk = ~clk;

  uart_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .tx_byte(tx_byte),
    .tx_enable(tx_enable), .tx_busy(tx_busy), .rx_enable(rx_enable),
    .rx_byte(rx_byte), .byte_available(byte_available)
  );

  uart_8n1 lb (
    .clk(clk), .rst_n(rst_n), .rx(lb_line), .tx(lb_line), .tx_byte(lb_tx_byte),
    .tx_enable(lb_tx_enable), .tx_busy(lb_busy), .rx_enable(1'b1),
    .rx_byte(lb_rx_byte), .byte_available(lb_avail)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_available === 1'b1) begin
      pulses++;
      last_pulse_cyc = cyc;
    end
    if (lb_avail === 1'b1) lb_q.push_back(lb_rx_byte);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ideal 8N1 frame on rx; rx_enable optionally dropped after drop_at cycles.
  task automatic drive_rx_frame(input logic [7:0] b, input logic stop, input int drop_at);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      for (int c = 0; c < CPB; c++) begin
        if (i * CPB + c == drop_at) rx_enable = 1'b0;
        tick(1);
      end
    end
    rx = 1'b1;
  endtask

  task automatic tx_single(input logic [7:0] b, input logic mid_strobe);
    logic [9:0] f;
    int ok[10];
    int busy_n;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) ok[i] = 0;
    busy_n = 0;
    tx_byte = b;
    tx_enable = 1'b1;
    tick(1);
    tx_enable = 1'b0;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (tx === f[c / CPB]) ok[c / CPB]++;
      if (tx_busy === 1'b1) busy_n++;
      if (mid_strobe && c == 50) begin
        tx_byte = 8'hFF;
        tx_enable = 1'b1;
      end
      if (mid_strobe && c == 51) tx_enable = 1'b0;
    end
    for (int i = 0; i < 10; i++) check($sformatf("tx_bit%0d_of_%02h", i, b), ok[i], CPB);
    check("tx_busy_len", busy_n, 10 * CPB);
    @(negedge clk);
    check("tx_idle_after", {tx, tx_busy}, 2'b10);
    tick(1);
  endtask

  // Random bytes sent back-to-back with tx_enable held; decoded at bit centres.
  task automatic tx_stream(input int n);
    logic [7:0] bytes[4];
    logic [9:0] got;
    int busy_n;
    busy_n = 0;
    for (int k = 0; k < n; k++) bytes[k] = 8'($urandom);
    tx_byte = bytes[0];
    tx_enable = 1'b1;
    tick(1);
    for (int c = 0; c < n * 10 * CPB; c++) begin
      @(negedge clk);
      line_buf[c] = tx;
      if (tx_busy === 1'b1) busy_n++;
      if (c % (10 * CPB) == 5 * CPB) begin
        if (c / (10 * CPB) + 1 < n) tx_byte = bytes[c / (10 * CPB) + 1];
        else tx_enable = 1'b0;
      end
    end
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 10; i++) got[i] = line_buf[k * 10 * CPB + i * CPB + CPB / 2];
      check($sformatf("tx_stream_frame%0d", k), got, {1'b1, bytes[k], 1'b0});
    end
    check("tx_stream_busy_len", busy_n, n * 10 * CPB);
    @(negedge clk);
    check("tx_stream_idle", {tx, tx_busy}, 2'b10);
    tick(1);
  endtask

  initial begin
    int p0, s, lat;
    logic [7:0] model_last, b;
    logic stop;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, -1, 1'b0, 1, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 1'b1, -1, 1'b1, 0, 8'hA5};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, -1, 1'b0, 0, 8'hA5};
    vecs[3] = '{8'h81, 1'b1, 1'b1, -1, 1'b0, 1, 8'h81};
    vecs[4] = '{8'h99, 1'b1, 1'b0, -1, 1'b0, 0, 8'h81};
    vecs[5] = '{8'h42, 1'b1, 1'b1, 40, 1'b0, 1, 8'h42};

    rst_n = 1'b0; rx = 1'b1; tx_enable = 1'b0; tx_byte = 8'h00; rx_enable = 1'b1;
    lb_tx_enable = 1'b0; lb_tx_byte = 8'h00;
    tick(3);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_byte_available", byte_available, 1'b0);
    rst_n = 1'b1;
    tick(100);
    check("idle_no_pulse", pulses, 0);
    check("idle_outputs", {tx, tx_busy, rx_byte}, {1'b1, 1'b0, 8'h00});

    tx_single(8'h55, 1'b1);
    tx_single(8'hC3, 1'b0);
    tx_stream(4);

    for (int i = 0; i < 6; i++) begin
      p0 = pulses;
      rx_enable = vecs[i].en;
      s = cyc;
      if (vecs[i].glitch) begin
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
      end else begin
        drive_rx_frame(vecs[i].data, vecs[i].stop, vecs[i].drop_at);
      end
      tick(30);
      rx_enable = 1'b1;
      check($sformatf("rx_vec%0d_pulses", i), pulses - p0, vecs[i].exp_pulses);
      check($sformatf("rx_vec%0d_byte", i), rx_byte, vecs[i].exp_byte);
      if (i == 0) begin
        lat = last_pulse_cyc - s;
        check("rx_latency_in_150_160", (lat >= 150 && lat <= 160), 1'b1);
      end
    end
    tick(100);
    check("rx_byte_held", rx_byte, 8'h42);

    model_last = 8'h42;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      p0 = pulses;
      drive_rx_frame(b, stop, -1);
      tick(20 + $urandom_range(0, 10));
      if (stop) model_last = b;
      check($sformatf("rx_rand%0d_pulses", k), pulses - p0, stop ? 1 : 0);
      check($sformatf("rx_rand%0d_byte", k), rx_byte, model_last);
    end

    // Simultaneous TX strobe while a frame is received.
    p0 = pulses;
    fork
      tx_single(8'h96, 1'b0);
      drive_rx_frame(8'h6B, 1'b1, -1);
    join
    tick(30);
    check("duplex_rx_pulses", pulses - p0, 1);
    check("duplex_rx_byte", rx_byte, 8'h6B);

    lb_q.delete();
    lb_tx_byte = 8'h00;
    lb_tx_enable = 1'b1;
    tick(1);
    tick(520);
    lb_tx_byte = 8'hFF;
    tick(1040);
    lb_tx_byte = 8'h30;
    tick(1040);
    lb_tx_enable = 1'b0;
    tick(700);
    check("lb_count", lb_q.size(), 3);
    check("lb_byte0", (lb_q.size() > 0) ? lb_q[0] : 8'hEE, 8'h00);
    check("lb_byte1", (lb_q.size() > 1) ? lb_q[1] : 8'hEE, 8'hFF);
    check("lb_byte2", (lb_q.size() > 2) ? lb_q[2] : 8'hEE, 8'h30);

    tx_byte = 8'h00;
    tx_enable = 1'b1;
    tick(1);
    tx_enable = 1'b0;
    tick(30);
    check("midframe_tx_low", tx, 1'b0);
    rst_n = 1'b0;
    tick(1);
    check("midrst_outputs", {tx, tx_busy, rx_byte, byte_available}, {1'b1, 1'b0, 8'h00, 1'b0});
    rst_n = 1'b1;
    tick(40);
    check("midrst_aborted", {tx, tx_busy}, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
